// File: rtl/back_propagation_hidden_1_scheduler.sv
// Hidden-1 back-propagation scheduler: streams (delta, weight) pairs into the
// shared node pipeline and collects one error sum per hidden-1 node.
module back_propagation_hidden_1_scheduler #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_DELTA         = 24,
  parameter int NUM_NODE          = 24,
  parameter int DELTA_ADDR_WIDTH  = 5,
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int INDEX_WIDTH       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_rd_en,
  output logic [DELTA_ADDR_WIDTH-1:0]  o_delta_addr,
  output logic [WEIGHT_ADDR_WIDTH-1:0] o_weight_addr,
  input  logic [DATA_WIDTH-1:0]        i_delta_data,
  input  logic [DATA_WIDTH-1:0]        i_weight_data,
  output logic                         o_node_valid,
  output logic [DATA_WIDTH-1:0]        o_node_delta,
  output logic [DATA_WIDTH-1:0]        o_node_weight,
  input  logic                         i_node_valid,
  input  logic [DATA_WIDTH-1:0]        i_node_data,
  output logic                         o_err_valid,
  output logic [DATA_WIDTH-1:0]        o_err_data,
  output logic [INDEX_WIDTH-1:0]       o_err_index
);

  // Result counter must be able to hold NUM_NODE itself (the "all collected" value).
  localparam int RES_W = $clog2(NUM_NODE + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                   state;
  logic [INDEX_WIDTH-1:0]   node_j;
  logic [RES_W-1:0]         res_cnt;
  logic                     last_k;
  logic                     last_j;
  logic                     collecting;
  logic                     res_full;

  assign last_k     = (o_delta_addr == DELTA_ADDR_WIDTH'(NUM_DELTA - 1));
  assign last_j     = (node_j == INDEX_WIDTH'(NUM_NODE - 1));
  assign collecting = (state == ISSUE) || (state == DRAIN);
  assign res_full   = (res_cnt == RES_W'(NUM_NODE));

  // RAM read data already arrives aligned with o_node_valid, so it is forwarded unregistered.
  assign o_node_delta  = i_delta_data;
  assign o_node_weight = i_weight_data;

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; the async reset clears each one, including the data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      node_j        <= '0;
      res_cnt       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rd_en       <= 1'b0;
      o_delta_addr  <= '0;
      o_weight_addr <= '0;
      o_node_valid  <= 1'b0;
      o_err_valid   <= 1'b0;
      o_err_data    <= '0;
      o_err_index   <= '0;
    end else begin
      o_node_valid <= o_rd_en;
      o_err_valid  <= 1'b0;
      o_done       <= 1'b0;

      // Results may overlap the issue phase; extras beyond NUM_NODE are dropped.
      if (collecting && i_node_valid && !res_full) begin
        o_err_valid <= 1'b1;
        o_err_data  <= i_node_data;
        o_err_index <= INDEX_WIDTH'(res_cnt);
        res_cnt     <= res_cnt + RES_W'(1);
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= ISSUE;
            o_busy        <= 1'b1;
            o_rd_en       <= 1'b1;
            o_delta_addr  <= '0;
            o_weight_addr <= '0;
            node_j        <= '0;
          end
        end

        ISSUE: begin
          if (last_k && last_j) begin
            state         <= DRAIN;
            o_rd_en       <= 1'b0;
            o_delta_addr  <= '0;
            o_weight_addr <= '0;
            node_j        <= '0;
          end else begin
            // Weight address walks j*NUM_DELTA+k linearly, so a plain increment suffices.
            o_weight_addr <= o_weight_addr + WEIGHT_ADDR_WIDTH'(1);
            if (last_k) begin
              o_delta_addr <= '0;
              node_j       <= node_j + INDEX_WIDTH'(1);
            end else begin
              o_delta_addr <= o_delta_addr + DELTA_ADDR_WIDTH'(1);
            end
          end
        end

        DRAIN: begin
          if (res_full) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end

        DONE: begin
          state         <= IDLE;
          res_cnt       <= '0;
          node_j        <= '0;
          o_delta_addr  <= '0;
          o_weight_addr <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_back_propagation_hidden_1_scheduler.sv
// Directed bench for the hidden-1 scheduler: a small 2x3 instance for address
// sequencing and a default 24x24 instance driven by RAM and node-pipeline models.
module tb_back_propagation_hidden_1_scheduler;

  localparam int ND = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_rd_en;
  logic [4:0]  o_delta_addr;
  logic [9:0]  o_weight_addr;
  logic [31:0] i_delta_data, i_weight_data;
  logic        o_node_valid;
  logic [31:0] o_node_delta, o_node_weight;
  logic        i_node_valid;
  logic [31:0] i_node_data;
  logic        o_err_valid;
  logic [31:0] o_err_data;
  logic [4:0]  o_err_index;

  logic        model_valid, spur_valid;
  logic [31:0] model_data, spur_data;
  assign i_node_valid = model_valid | spur_valid;
  assign i_node_data  = spur_valid ? spur_data : model_data;

  // Small-configuration DUT (NUM_NODE=2, NUM_DELTA=3)
  logic        i_start_s = 1'b0;
  logic        o_busy_s, o_done_s, o_rd_en_s;
  logic [4:0]  o_delta_addr_s;
  logic [9:0]  o_weight_addr_s;
  logic [31:0] i_delta_data_s, i_weight_data_s;
  logic        o_node_valid_s;
  logic [31:0] o_node_delta_s, o_node_weight_s;
  logic        i_node_valid_s = 1'b0;
  logic [31:0] i_node_data_s = 32'h0;
  logic        o_err_valid_s;
  logic [31:0] o_err_data_s;
  logic [4:0]  o_err_index_s;

  back_propagation_hidden_1_scheduler dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_delta_addr(o_delta_addr), .o_weight_addr(o_weight_addr),
    .i_delta_data(i_delta_data), .i_weight_data(i_weight_data),
    .o_node_valid(o_node_valid), .o_node_delta(o_node_delta), .o_node_weight(o_node_weight),
    .i_node_valid(i_node_valid), .i_node_data(i_node_data),
    .o_err_valid(o_err_valid), .o_err_data(o_err_data), .o_err_index(o_err_index)
  );

  back_propagation_hidden_1_scheduler #(.NUM_DELTA(3), .NUM_NODE(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(i_start_s), .o_busy(o_busy_s), .o_done(o_done_s),
    .o_rd_en(o_rd_en_s), .o_delta_addr(o_delta_addr_s), .o_weight_addr(o_weight_addr_s),
    .i_delta_data(i_delta_data_s), .i_weight_data(i_weight_data_s),
    .o_node_valid(o_node_valid_s), .o_node_delta(o_node_delta_s), .o_node_weight(o_node_weight_s),
    .i_node_valid(i_node_valid_s), .i_node_data(i_node_data_s),
    .o_err_valid(o_err_valid_s), .o_err_data(o_err_data_s), .o_err_index(o_err_index_s)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact float32 encode/decode for small non-negative integers.
  function automatic logic [31:0] i2f(input int n);
    int p;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++) if (n[b]) p = b;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    return int'({8'd0, 1'b1, f[22:0]} >> (23 - e));
  endfunction

  // RAM models: one-cycle read latency, sampled just after the active edge.
  initial begin
    logic pv, pv_s;
    logic [31:0] pd, pw, pd_s, pw_s;
    pv = 1'b0; pd = '0; pw = '0; pv_s = 1'b0; pd_s = '0; pw_s = '0;
    i_delta_data = '0; i_weight_data = '0; i_delta_data_s = '0; i_weight_data_s = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0; pv_s = 1'b0;
        i_delta_data = '0; i_weight_data = '0; i_delta_data_s = '0; i_weight_data_s = '0;
      end else begin
        i_delta_data    = pv ? pd : 32'h0;
        i_weight_data   = pv ? pw : 32'h0;
        i_delta_data_s  = pv_s ? pd_s : 32'h0;
        i_weight_data_s = pv_s ? pw_s : 32'h0;
        pv   = o_rd_en;
        pd   = 32'h3F80_0000;
        pw   = i2f(int'(o_weight_addr) / ND);
        pv_s = o_rd_en_s;
        pd_s = 32'hD000_0000 | 32'(o_delta_addr_s);
        pw_s = 32'hE000_0000 | 32'(o_weight_addr_s);
      end
    end
  end

  // Behavioural node: multiply, accumulate 24 pairs, emit sum after an 8-stage delay.
  initial begin
    int acc, cnt;
    logic dv [8];
    logic [31:0] dd [8];
    acc = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin dv[i] = 1'b0; dd[i] = '0; end
    model_valid = 1'b0; model_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = 0; cnt = 0; model_valid = 1'b0; model_data = '0;
        for (int i = 0; i < 8; i++) begin dv[i] = 1'b0; dd[i] = '0; end
      end else begin
        model_valid = dv[7];
        model_data  = dd[7];
        for (int i = 7; i > 0; i--) begin dv[i] = dv[i-1]; dd[i] = dd[i-1]; end
        dv[0] = 1'b0; dd[0] = '0;
        if (o_node_valid) begin
          acc += f2i(o_node_delta) * f2i(o_node_weight);
          cnt++;
          if (cnt == ND) begin dv[0] = 1'b1; dd[0] = i2f(acc); acc = 0; cnt = 0; end
        end
      end
    end
  end

  // Collects one full pass of results on the default DUT; expects index j, data 24.0*j.
  task automatic run_pass(input string tag);
    int n;
    bit got;
    n = 0; got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (o_err_valid) begin
        check(32'(o_err_index), n, {tag, "_index"});
        check(o_err_data, i2f(ND * n), {tag, "_data"});
        n++;
      end
      if (o_done) begin
        got = 1'b1;
        check(n, ND, {tag, "_results_before_done"});
        check(32'(o_busy), 0, {tag, "_busy_in_done"});
      end
    end
    check(32'(got), 1, {tag, "_done_seen"});
    @(negedge clk);
    check(32'(o_done), 0, {tag, "_done_one_cycle"});
  endtask

  initial begin
    bit found;
    spur_valid = 1'b0; spur_data = '0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_start = 1'($urandom); i_start_s = 1'($urandom);
      spur_valid = 1'($urandom); spur_data = $urandom;
    end
    #1;
    check(32'(o_busy), 0, "rst_busy");
    check(32'(o_done), 0, "rst_done");
    check(32'(o_rd_en), 0, "rst_rd_en");
    check(32'(o_node_valid), 0, "rst_node_valid");
    check(32'(o_err_valid), 0, "rst_err_valid");
    check(32'(o_delta_addr), 0, "rst_delta_addr");
    check(32'(o_weight_addr), 0, "rst_weight_addr");
    check(o_err_data, 0, "rst_err_data");
    check(32'(o_err_index), 0, "rst_err_index");
    check(32'(o_busy_s), 0, "rst_busy_small");
    @(negedge clk);
    i_start = 1'b0; i_start_s = 1'b0; spur_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check(32'(o_busy), 0, "idle_busy");
    check(32'(o_rd_en), 0, "idle_rd_en");
    check(32'(o_err_valid), 0, "idle_err_valid");

    // Small config: 2 nodes x 3 deltas
    i_start_s = 1'b1;
    @(negedge clk);
    i_start_s = 1'b0;
    check(32'(o_busy_s), 1, "s_busy_e0");
    for (int c = 0; c < 8; c++) begin
      check(32'(o_rd_en_s), (c < 6) ? 1 : 0, $sformatf("s_rd_en_c%0d", c));
      if (c < 6) begin
        check(32'(o_delta_addr_s), c % 3, $sformatf("s_delta_addr_c%0d", c));
        check(32'(o_weight_addr_s), c, $sformatf("s_weight_addr_c%0d", c));
      end
      check(32'(o_node_valid_s), (c >= 1 && c <= 6) ? 1 : 0, $sformatf("s_node_valid_c%0d", c));
      if (c >= 1 && c <= 6) begin
        check(o_node_delta_s, 32'hD000_0000 | 32'((c - 1) % 3), $sformatf("s_node_delta_c%0d", c));
        check(o_node_weight_s, 32'hE000_0000 | 32'(c - 1), $sformatf("s_node_weight_c%0d", c));
      end
      @(negedge clk);
    end
    i_node_valid_s = 1'b1; i_node_data_s = 32'h1111_1111;
    @(negedge clk);
    check(32'(o_err_valid_s), 1, "s_err_valid0");
    check(32'(o_err_index_s), 0, "s_err_index0");
    check(o_err_data_s, 32'h1111_1111, "s_err_data0");
    i_node_data_s = 32'h2222_2222;
    @(negedge clk);
    check(32'(o_err_index_s), 1, "s_err_index1");
    check(o_err_data_s, 32'h2222_2222, "s_err_data1");
    i_node_valid_s = 1'b0;
    @(negedge clk);
    check(32'(o_done_s), 1, "s_done");
    check(32'(o_busy_s), 0, "s_busy_done");
    @(negedge clk);
    check(32'(o_done_s), 0, "s_done_one_cycle");

    // Pass A: single start pulse
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check(32'(o_busy), 1, "a_busy_e0");
    check(32'(o_rd_en), 1, "a_rd_en_e0");
    run_pass("a");

    // Pass B: start held through the pass and DONE
    i_start = 1'b1;
    @(negedge clk);
    check(32'(o_busy), 1, "b_busy_e0");
    run_pass("b");
    check(32'(o_busy), 0, "b_no_restart_busy");
    check(32'(o_rd_en), 0, "b_no_restart_rd_en");
    @(negedge clk);
    i_start = 1'b0;
    check(32'(o_busy), 1, "c_restart_busy");
    check(32'(o_delta_addr), 0, "c_restart_delta_addr");
    check(32'(o_weight_addr), 0, "c_restart_weight_addr");

    // Pass C: abort with reset at j=5, k=10
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (o_delta_addr == 5'd10 && o_weight_addr == 10'd130) found = 1'b1;
    end
    check(32'(found), 1, "c_reach_j5_k10");
    rst_n = 1'b0;
    #1;
    check(32'(o_busy), 0, "c_abort_busy");
    check(32'(o_rd_en), 0, "c_abort_rd_en");
    check(32'(o_node_valid), 0, "c_abort_node_valid");
    check(32'(o_delta_addr), 0, "c_abort_delta_addr");
    check(32'(o_weight_addr), 0, "c_abort_weight_addr");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Spurious node result while idle
    @(negedge clk);
    spur_valid = 1'b1; spur_data = 32'hDEAD_BEEF;
    @(negedge clk);
    spur_valid = 1'b0;
    check(32'(o_err_valid), 0, "spur_err_valid");
    @(negedge clk);
    check(32'(o_err_valid), 0, "spur_err_valid_late");
    check(32'(o_busy), 0, "spur_busy");

    // Pass D: fresh pass after abort and spurious input
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check(32'(o_delta_addr), 0, "d_delta_addr0");
    check(32'(o_weight_addr), 0, "d_weight_addr0");
    check(32'(o_rd_en), 1, "d_rd_en0");
    @(negedge clk);
    check(32'(o_delta_addr), 1, "d_delta_addr1");
    check(32'(o_weight_addr), 1, "d_weight_addr1");
    run_pass("d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/back_propagation_hidden_1_scheduler.md
Name: back_propagation_hidden_1_scheduler

Overview:
- Sequences the hidden-1 back-propagation pass.
- For each of NUM_NODE hidden-1 nodes, streams NUM_DELTA (delta, weight) pairs from delta and weight RAMs into the shared multiply/24-input-adder node pipeline, one pair per cycle, with no gaps.
- Collects the per-node error sums the pipeline returns, tags each with its node index, and signals completion.
- Sits between the layer controller, the RAMs, and the node datapath.

Parameters:
- DATA_WIDTH, 32, float32 word width.
- NUM_DELTA, 24, pairs per node; must equal the node adder fan-in.
- NUM_NODE, 24, hidden-1 nodes per pass.
- DELTA_ADDR_WIDTH, 5, delta RAM address width, ≥ clog2(NUM_DELTA).
- WEIGHT_ADDR_WIDTH, 10, weight RAM address width, ≥ clog2(NUM_NODE*NUM_DELTA).
- INDEX_WIDTH, 5, node index width, ≥ clog2(NUM_NODE).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start a pass; sampled only in IDLE.
- o_busy  out  1  high in ISSUE and DRAIN.
- o_done  out  1  one-cycle pulse at pass end.
- o_rd_en  out  1  read enable to both RAMs.
- o_delta_addr  out  DELTA_ADDR_WIDTH  delta RAM address k.
- o_weight_addr  out  WEIGHT_ADDR_WIDTH  weight RAM address, j*NUM_DELTA+k.
- i_delta_data  in  DATA_WIDTH  delta RAM read data; valid one cycle after o_rd_en.
- i_weight_data  in  DATA_WIDTH  weight RAM read data; same latency.
- o_node_valid  out  1  pair valid to node pipeline.
- o_node_delta  out  DATA_WIDTH  delta to node; direct pass of i_delta_data.
- o_node_weight  out  DATA_WIDTH  weight to node; direct pass of i_weight_data.
- i_node_valid  in  1  node pipeline result valid.
- i_node_data  in  DATA_WIDTH  node pipeline result.
- o_err_valid  out  1  registered result valid.
- o_err_data  out  DATA_WIDTH  registered result.
- o_err_index  out  INDEX_WIDTH  node index j of the result.

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters 0; o_busy, o_done, o_rd_en, o_node_valid, o_err_valid = 0; addresses, o_err_data, o_err_index = 0. Reset asserted mid-pass aborts immediately.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 at edge E0 → ISSUE.
  - At E0, o_rd_en=1 and addresses (j=0, k=0) are registered.
  - i_node_valid in IDLE is ignored: no o_err_valid.
- ISSUE:
  - One pair issued per cycle; k increments each edge; on k=NUM_DELTA-1, k wraps to 0 and j increments.
  - o_weight_addr = j*NUM_DELTA+k, computed by an incrementing counter, not a multiplier.
  - After the pair (NUM_NODE-1, NUM_DELTA-1) is issued, the next edge clears o_rd_en and moves to DRAIN.
- Node valid: o_node_valid = o_rd_en delayed one cycle (registered), aligned with RAM data.
  - High for exactly NUM_NODE*NUM_DELTA consecutive cycles, starting after E1.
  - o_node_delta and o_node_weight pass through combinationally.
- Result collection (ISSUE or DRAIN):
  - Each i_node_valid registers o_err_valid=1, o_err_data=i_node_data, o_err_index=result counter; the counter then increments.
  - Latency is 1 cycle.
  - Results may arrive during ISSUE, overlapping with issue.
- DRAIN: when the result counter reaches NUM_NODE (last result registered), → DONE.
- DONE: o_done=1 for one cycle, o_busy=0, counters cleared; next edge → IDLE.
- i_start outside IDLE, including in DONE, is ignored; back-to-back passes need a start in IDLE.
- o_busy is registered: high from E0 until the edge entering DONE.
- A result arriving on the same cycle as the last issue is counted normally.
- Results beyond NUM_NODE in a pass cannot arrive by construction; if they do, they are dropped.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0, o_busy=0; release with no start → stays idle.
- Small config (NUM_NODE=2, NUM_DELTA=3), start → delta addr sequence 0,1,2,0,1,2; weight addr sequence 0..5; o_rd_en high 6 cycles; o_node_valid high 6 cycles, one cycle later; node data equals RAM data.
- Default config with a behavioural node model (latency 7+adder): delta k=1.0, weight j*24+k=j → o_err_valid 24 times; o_err_index 0..23; o_err_data=24.0*j; o_done pulses once, after the last result.
- i_start held high for the whole pass and through DONE → no second pass until IDLE is re-entered; then a new pass starts and addresses restart at 0.
- rst_n pulsed low mid-ISSUE (j=5, k=10) → outputs 0 immediately; after release and start, issue restarts at j=0, k=0.
- Spurious i_node_valid in IDLE → no o_err_valid and no counter change; the next pass still yields indices 0..NUM_NODE-1.
